// File: rtl/fll_scheduler.sv
// fll_scheduler: upstream sequencer for the shared FLL.
// Collects per-channel update requests in a pending mask and serves them one at a time in
// round-robin order: read the channel history, hold it on the FLL inputs, pulse fll_start for
// one FLL clock period, wait for the result (with timeout) and write it back.
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   req_valid, req_tag         update request strobe and channel
//   hist_rd_en/tag/data        history memory read (data returns one cycle after rd_en)
//   fll_start, fll_tag         FLL launch strobe and in-flight channel
//   fll_iq_k .. fll_w_df_dot_k held history presented to the FLL
//   fll_result_ready, fll_*    FLL result strobe and result fields
//   wr_en, wr_tag, wr_*        state-memory writeback
//   busy                       sequencer not idle
//   overrun_err, timeout_err,
//   spurious_err               sticky error flags
module fll_scheduler #(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned TAG_W      = 3,
    parameter int unsigned IQ_W       = 16,
    parameter int unsigned ACC_W      = 17,
    parameter int unsigned DS_W       = 20,
    parameter int unsigned DSD_W      = 20,
    parameter int unsigned DINC_W     = 20,
    parameter int unsigned START_HOLD = 32,
    parameter int unsigned TIMEOUT    = 1024,
    localparam int unsigned HIST_W    = 2 * IQ_W + 4 * ACC_W + DS_W + DSD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              hist_rd_en,
    output logic [TAG_W-1:0]  hist_rd_tag,
    input  logic [HIST_W-1:0] hist_rd_data,
    output logic              fll_start,
    output logic [TAG_W-1:0]  fll_tag,
    output logic [IQ_W-1:0]   fll_iq_k,
    output logic [IQ_W-1:0]   fll_iq_km1,
    output logic [ACC_W-1:0]  fll_i_k,
    output logic [ACC_W-1:0]  fll_q_k,
    output logic [ACC_W-1:0]  fll_i_km1,
    output logic [ACC_W-1:0]  fll_q_km1,
    output logic [DS_W-1:0]   fll_w_df_k,
    output logic [DSD_W-1:0]  fll_w_df_dot_k,
    input  logic              fll_result_ready,
    input  logic [DINC_W-1:0] fll_doppler_inc,
    input  logic [DS_W-1:0]   fll_w_df_kp1,
    input  logic [DSD_W-1:0]  fll_w_df_dot_kp1,
    output logic              wr_en,
    output logic [TAG_W-1:0]  wr_tag,
    output logic [DINC_W-1:0] wr_doppler_inc,
    output logic [DS_W-1:0]   wr_w_df,
    output logic [DSD_W-1:0]  wr_w_df_dot,
    output logic              busy,
    output logic              overrun_err,
    output logic              timeout_err,
    output logic              spurious_err
);

    localparam int unsigned CNT_MAX = (TIMEOUT > START_HOLD) ? TIMEOUT : START_HOLD;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Bit offsets of the history fields, LSB first.
    localparam int unsigned OFF_WDD   = 0;
    localparam int unsigned OFF_WD    = OFF_WDD + DSD_W;
    localparam int unsigned OFF_QKM1  = OFF_WD + DS_W;
    localparam int unsigned OFF_IKM1  = OFF_QKM1 + ACC_W;
    localparam int unsigned OFF_QK    = OFF_IKM1 + ACC_W;
    localparam int unsigned OFF_IK    = OFF_QK + ACC_W;
    localparam int unsigned OFF_IQKM1 = OFF_IK + ACC_W;
    localparam int unsigned OFF_IQK   = OFF_IQKM1 + IQ_W;

    typedef enum logic [2:0] {StIdle, StRead, StLaunch, StWait, StWrite} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [NUM_CH-1:0]  req_set, grant_clr;
    logic [TAG_W-1:0]   ptr_q;
    logic [TAG_W-1:0]   pick_tag, cand;
    logic               pick_found;
    logic               grant;
    logic               overrun;
    logic               timeout_hit;
    logic [HIST_W-1:0]  hold_q;
    logic [TAG_W-1:0]   fll_tag_q;
    logic [DINC_W-1:0]  wr_inc_q;
    logic [DS_W-1:0]    wr_wdf_q;
    logic [DSD_W-1:0]   wr_wdfd_q;
    logic               overrun_q, timeout_q, spurious_q;

    // Round-robin pick: first pending channel strictly after the pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_tag   = '0;
        cand       = '0;
        for (int i = 1; i <= int'(NUM_CH); i++) begin
            cand = TAG_W'((int'(ptr_q) + i) % NUM_CH);
            if (!pick_found && mask_q[cand]) begin
                pick_found = 1'b1;
                pick_tag   = cand;
            end
        end
    end

    assign grant = (state_q == StIdle) && pick_found;

    // Out-of-range tags match no bit and are dropped. A set in the grant cycle wins over the
    // clear, and a request for the channel being granted counts as a re-arm, not an overrun.
    always_comb begin
        req_set   = '0;
        grant_clr = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (req_valid && req_tag == TAG_W'(i)) req_set[i] = 1'b1;
            if (grant && pick_tag == TAG_W'(i))    grant_clr[i] = 1'b1;
        end
        mask_d  = (mask_q & ~grant_clr) | req_set;
        overrun = |(req_set & mask_q & ~grant_clr);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timeout_hit = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (grant) state_d = StRead;
            end
            StRead: begin
                state_d = StLaunch;
                cnt_d   = '0;
            end
            StLaunch: begin
                if (cnt_q == CNT_W'(START_HOLD - 1)) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWait: begin
                // A result on the final timeout cycle still wins.
                if (fll_result_ready) begin
                    state_d = StWrite;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = StIdle;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWrite: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mask_q     <= '0;
            ptr_q      <= TAG_W'(NUM_CH - 1);
            hold_q     <= '0;
            fll_tag_q  <= '0;
            wr_inc_q   <= '0;
            wr_wdf_q   <= '0;
            wr_wdfd_q  <= '0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            if (grant) ptr_q <= pick_tag;
            // The pointer holds the granted channel while in READ.
            if (state_q == StRead) begin
                hold_q    <= hist_rd_data;
                fll_tag_q <= ptr_q;
            end
            if (state_q == StWait && fll_result_ready) begin
                wr_inc_q  <= fll_doppler_inc;
                wr_wdf_q  <= fll_w_df_kp1;
                wr_wdfd_q <= fll_w_df_dot_kp1;
            end
            if (overrun)     overrun_q <= 1'b1;
            if (timeout_hit) timeout_q <= 1'b1;
            if (fll_result_ready && state_q != StWait) spurious_q <= 1'b1;
        end
    end

    assign hist_rd_en     = grant;
    assign hist_rd_tag    = grant ? pick_tag : '0;
    assign fll_start      = (state_q == StLaunch);
    assign fll_tag        = fll_tag_q;
    assign fll_iq_k       = hold_q[OFF_IQK +: IQ_W];
    assign fll_iq_km1     = hold_q[OFF_IQKM1 +: IQ_W];
    assign fll_i_k        = hold_q[OFF_IK +: ACC_W];
    assign fll_q_k        = hold_q[OFF_QK +: ACC_W];
    assign fll_i_km1      = hold_q[OFF_IKM1 +: ACC_W];
    assign fll_q_km1      = hold_q[OFF_QKM1 +: ACC_W];
    assign fll_w_df_k     = hold_q[OFF_WD +: DS_W];
    assign fll_w_df_dot_k = hold_q[OFF_WDD +: DSD_W];
    assign wr_en          = (state_q == StWrite);
    assign wr_tag         = fll_tag_q;
    assign wr_doppler_inc = wr_inc_q;
    assign wr_w_df        = wr_wdf_q;
    assign wr_w_df_dot    = wr_wdfd_q;
    assign busy           = (state_q != StIdle);
    assign overrun_err    = overrun_q;
    assign timeout_err    = timeout_q;
    assign spurious_err   = spurious_q;

endmodule

// File: tb/tb_fll_scheduler.sv
// Testbench for fll_scheduler: history memory and FLL models, scoreboard of expected writebacks.
module tb_fll_scheduler;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_valid = 1'b0;
    logic [2:0]   req_tag = '0;
    logic         hist_rd_en;
    logic [2:0]   hist_rd_tag;
    logic [139:0] hist_rd_data = '0;
    logic         fll_start;
    logic [2:0]   fll_tag;
    logic [15:0]  fll_iq_k, fll_iq_km1;
    logic [16:0]  fll_i_k, fll_q_k, fll_i_km1, fll_q_km1;
    logic [19:0]  fll_w_df_k, fll_w_df_dot_k;
    logic         fll_result_ready = 1'b0;
    logic [19:0]  fll_doppler_inc = '0, fll_w_df_kp1 = '0, fll_w_df_dot_kp1 = '0;
    logic         wr_en;
    logic [2:0]   wr_tag;
    logic [19:0]  wr_doppler_inc, wr_w_df, wr_w_df_dot;
    logic         busy, overrun_err, timeout_err, spurious_err;

    fll_scheduler dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_tag(req_tag),
        .hist_rd_en(hist_rd_en), .hist_rd_tag(hist_rd_tag), .hist_rd_data(hist_rd_data),
        .fll_start(fll_start), .fll_tag(fll_tag), .fll_iq_k(fll_iq_k), .fll_iq_km1(fll_iq_km1),
        .fll_i_k(fll_i_k), .fll_q_k(fll_q_k), .fll_i_km1(fll_i_km1), .fll_q_km1(fll_q_km1),
        .fll_w_df_k(fll_w_df_k), .fll_w_df_dot_k(fll_w_df_dot_k),
        .fll_result_ready(fll_result_ready), .fll_doppler_inc(fll_doppler_inc),
        .fll_w_df_kp1(fll_w_df_kp1), .fll_w_df_dot_kp1(fll_w_df_dot_kp1),
        .wr_en(wr_en), .wr_tag(wr_tag), .wr_doppler_inc(wr_doppler_inc), .wr_w_df(wr_w_df),
        .wr_w_df_dot(wr_w_df_dot), .busy(busy), .overrun_err(overrun_err),
        .timeout_err(timeout_err), .spurious_err(spurious_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   tag;
        logic [139:0] hist;
    } ent_t;

    ent_t         sb[$];
    logic [139:0] hist_mem[8];
    int           n_vec = 0;
    int           n_err = 0;
    int           wr_cnt = 0, rd_cnt = 0, start_cnt = 0, launches = 0;
    int           cd = 0;
    int           latency = 100;
    logic         respond_en = 1'b1;
    int           spur_seq = 0, spur_ack = 0;
    logic         start_prev = 1'b0;

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // FLL transfer function: exercises iq_k, w_df and w_df_dot through the hold registers.
    function automatic logic [59:0] fll_fn(input logic [15:0] iq, input logic [19:0] wdf,
                                           input logic [19:0] wdfd);
        return {wdf ^ wdfd ^ {4'h0, iq}, wdf + wdfd, ~wdfd};
    endfunction

    function automatic logic [59:0] exp_res(input logic [139:0] h);
        return fll_fn(h[139:124], h[39:20], h[19:0]);
    endfunction

    // History memory: registered read.
    always @(posedge clk) if (hist_rd_en === 1'b1) hist_rd_data <= hist_mem[hist_rd_tag];

    // FLL model, launch counters and writeback scoreboard.
    always @(negedge clk) begin
        fll_result_ready = 1'b0;
        if (spur_seq != spur_ack) begin
            fll_result_ready = 1'b1;
            spur_ack = spur_seq;
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0) fll_result_ready = 1'b1;
        end
        if (fll_start === 1'b1) start_cnt++;
        if (fll_start === 1'b1 && start_prev === 1'b0) launches++;
        if (fll_start === 1'b0 && start_prev === 1'b1) begin
            if (sb.size() > 0) begin
                check("fll_tag", fll_tag, sb[0].tag);
                check("fll_hold", {fll_iq_k, fll_iq_km1, fll_i_k, fll_q_k, fll_i_km1, fll_q_km1,
                                   fll_w_df_k, fll_w_df_dot_k}, sb[0].hist);
            end
            if (respond_en) begin
                {fll_doppler_inc, fll_w_df_kp1, fll_w_df_dot_kp1} =
                    fll_fn(fll_iq_k, fll_w_df_k, fll_w_df_dot_k);
                cd = latency;
            end
        end
        start_prev = fll_start;
        if (hist_rd_en === 1'b1) rd_cnt++;
        if (wr_en === 1'b1) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                ent_t e;
                e = sb.pop_front();
                check("wr_tag", wr_tag, e.tag);
                check("wr_data", {wr_doppler_inc, wr_w_df, wr_w_df_dot}, exp_res(e.hist));
            end
        end
    end

    task automatic expect_tag(input logic [2:0] t);
        ent_t e;
        e.tag  = t;
        e.hist = hist_mem[t];
        sb.push_back(e);
    endtask

    task automatic send(input logic [2:0] t);
        req_valid = 1'b1;
        req_tag   = t;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wr_wait", wr_cnt >= target, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", busy, 0);
    endtask

    task automatic wait_start(input logic lvl, input int budget, input string name);
        int n = 0;
        while (fll_start !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, fll_start, lvl);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {hist_rd_en, hist_rd_tag, fll_start, fll_tag, wr_en, wr_tag, busy,
                               overrun_err, timeout_err, spurious_err}, 0);
        check({name, "_hold"}, {fll_iq_k, fll_iq_km1, fll_i_k, fll_q_k, fll_i_km1, fll_q_km1,
                                fll_w_df_k, fll_w_df_dot_k}, 0);
        check({name, "_wr"}, {wr_doppler_inc, wr_w_df, wr_w_df_dot}, 0);
    endtask

    initial begin
        int s0, l0, w0, r0, n;
        logic [159:0] rnd;
        for (int c = 0; c < 8; c++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
            hist_mem[c] = rnd[139:0];
        end

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset");

        // Single request, tag 3: rd_en next cycle, 32-cycle start, one exact writeback.
        s0 = start_cnt; l0 = launches; w0 = wr_cnt;
        expect_tag(3'd3);
        send(3'd3);
        check("rd_en_pulse", {hist_rd_en, hist_rd_tag}, {1'b1, 3'd3});
        @(negedge clk);
        check("rd_en_drop", hist_rd_en, 0);
        check("busy_read", busy, 1);
        wait_wr(w0 + 1, 400);
        wait_idle(10);
        check("start_hold", start_cnt - s0, 32);
        check("launch_once", launches - l0, 1);

        // Round robin from pointer 7: 7 first, then 5,1,6 arrive while busy -> 1,5,6.
        do_reset();
        s0 = start_cnt; l0 = launches; w0 = wr_cnt; r0 = rd_cnt;
        expect_tag(3'd7); expect_tag(3'd1); expect_tag(3'd5); expect_tag(3'd6);
        send(3'd7); send(3'd5); send(3'd1); send(3'd6);
        wait_wr(w0 + 4, 1200);
        wait_idle(10);
        check("rr_launches", launches - l0, 4);
        check("rr_reads", rd_cnt - r0, 4);
        check("rr_no_overrun", overrun_err, 0);

        // Duplicate request for pending tag 2 -> overrun, single writeback.
        w0 = wr_cnt; r0 = rd_cnt;
        expect_tag(3'd0); expect_tag(3'd2);
        send(3'd0); send(3'd2); send(3'd2);
        @(negedge clk);
        check("overrun_set", overrun_err, 1);
        wait_wr(w0 + 2, 800);
        repeat (200) @(negedge clk);
        check("overrun_single_wr", wr_cnt - w0, 2);
        check("overrun_reads", rd_cnt - r0, 2);

        // FLL silent: timeout after TIMEOUT cycles in WAIT, no writeback.
        respond_en = 1'b0;
        w0 = wr_cnt;
        expect_tag(3'd4);
        send(3'd4);
        wait_start(1'b1, 20, "to_start_hi");
        wait_start(1'b0, 50, "to_start_lo");
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("timeout_cycles", n, 1024);
        check("timeout_err", timeout_err, 1);
        check("timeout_no_wr", wr_cnt - w0, 0);
        void'(sb.pop_front());
        respond_en = 1'b1;
        expect_tag(3'd4);
        send(3'd4);
        wait_wr(w0 + 1, 400);
        wait_idle(10);

        // Spurious result during LAUNCH: flagged, writeback only on the real result.
        check("spurious_clear", spurious_err, 0);
        w0 = wr_cnt;
        expect_tag(3'd6);
        send(3'd6);
        wait_start(1'b1, 20, "sp_start_hi");
        spur_seq++;
        repeat (3) @(negedge clk);
        check("spurious_set", spurious_err, 1);
        check("spurious_no_wr", wr_cnt - w0, 0);
        wait_wr(w0 + 1, 400);
        repeat (150) @(negedge clk);
        check("spurious_single_wr", wr_cnt - w0, 1);

        // Reset during WAIT: outputs cleared, late result gives no writeback.
        w0 = wr_cnt;
        expect_tag(3'd5);
        send(3'd5);
        wait_start(1'b1, 20, "rw_start_hi");
        wait_start(1'b0, 50, "rw_start_lo");
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset_wait");
        void'(sb.pop_front());
        r0 = rd_cnt;
        repeat (150) @(negedge clk);
        check("reset_no_wr", wr_cnt - w0, 0);
        check("reset_mask_empty", rd_cnt - r0, 0);
        check("reset_late_spurious", spurious_err, 1);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
